// File: rtl/weight_buffer_read_sequencer_pkg.sv
// Shared types for the weight-buffer read sequencer: FSM states and the tag that
// travels alongside each RAM read through the latency-matching pipe.
package weight_seq_pkg;

    localparam int LATENCY_DEF = 2;
    localparam int IDX_W       = 12;
    localparam int PASS_W      = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } seq_state_e;

    // pass is carried so a replay can rewind the pass counter to the refused word
    typedef struct packed {
        logic              valid;
        logic [IDX_W-1:0]  row;
        logic [PASS_W-1:0] pass;
        logic              last;
    } tag_t;

endpackage

// File: rtl/weight_buffer_read_sequencer_tag_pipe.sv
// LATENCY-deep tag shift register; flush drops every in-flight valid in one cycle
// so a replay can restart issue without duplicate words reaching the consumer.
module wbuf_tag_pipe
    import weight_seq_pkg::*;
#(
    parameter int LATENCY = LATENCY_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic flush_i,
    input  tag_t push_i,
    output tag_t tail_o
);

    tag_t stage_q [LATENCY];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LATENCY; i++) stage_q[i] <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < LATENCY; i++) stage_q[i].valid <= 1'b0;
        end else begin
            stage_q[0] <= push_i;
            for (int i = 1; i < LATENCY; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign tail_o = stage_q[LATENCY-1];

endmodule

// File: rtl/weight_buffer_read_sequencer.sv
// Weight-buffer read sequencer: walks rows 0..ROWS-1 for N passes, tags RAM words,
// and replays refused words instead of buffering them. Optional WBUF_SEQ_PERF_EN adds replay_count.
module weight_buffer_read_sequencer
    import weight_seq_pkg::*;
#(
    parameter int ROWS        = 42,
    parameter int INDEX_WIDTH = IDX_W,
    parameter int LATENCY     = LATENCY_DEF,
    parameter int PASS_WIDTH  = PASS_W
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [PASS_WIDTH-1:0]  num_passes,
    output logic [INDEX_WIDTH-1:0] index,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INDEX_WIDTH-1:0] out_row,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done
`ifdef WBUF_SEQ_PERF_EN
    ,
    output logic [31:0]            replay_count
`endif
);

    localparam logic [INDEX_WIDTH-1:0] LAST_ROW = INDEX_WIDTH'(ROWS - 1);

    seq_state_e             state_q;
    logic [INDEX_WIDTH-1:0] index_q;
    logic [PASS_WIDTH-1:0]  pass_q;
    logic [PASS_WIDTH-1:0]  passes_q;
    logic                   busy_q;
    logic                   done_q;

    tag_t push_tag;
    tag_t tail;
    logic accept;
    logic refuse;
    logic issue_last;

    assign accept     = tail.valid & out_ready;
    assign refuse     = tail.valid & ~out_ready;
    assign issue_last = (index_q == LAST_ROW) && (pass_q == passes_q - 1'b1);

    always_comb begin
        push_tag       = '0;
        push_tag.valid = (state_q == ST_ISSUE);
        push_tag.row   = IDX_W'(index_q);
        push_tag.pass  = PASS_W'(pass_q);
        push_tag.last  = issue_last;
    end

    // A refusal flushes everything younger than the refused word; the push in that cycle is discarded too
    wbuf_tag_pipe #(
        .LATENCY(LATENCY)
    ) u_tag_pipe (
        .clk    (clk),
        .reset_n(reset_n),
        .flush_i(refuse),
        .push_i (push_tag),
        .tail_o (tail)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            index_q  <= '0;
            pass_q   <= '0;
            passes_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (num_passes != '0) begin
                            state_q  <= ST_ISSUE;
                            passes_q <= num_passes;
                            pass_q   <= '0;
                            index_q  <= '0;
                            busy_q   <= 1'b1;
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_ISSUE, ST_DRAIN: begin
                    if (refuse) begin
                        state_q <= ST_ISSUE;
                        index_q <= INDEX_WIDTH'(tail.row);
                        pass_q  <= PASS_WIDTH'(tail.pass);
                    end else if (accept && tail.last) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (state_q == ST_ISSUE) begin
                        // index holds on the final issue so DRAIN leaves the bank parked
                        if (issue_last) begin
                            state_q <= ST_DRAIN;
                        end else if (index_q == LAST_ROW) begin
                            index_q <= '0;
                            pass_q  <= pass_q + 1'b1;
                        end else begin
                            index_q <= index_q + 1'b1;
                        end
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign index     = index_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = tail.valid;
    assign out_row   = INDEX_WIDTH'(tail.row);
    assign out_last  = tail.last;

`ifdef WBUF_SEQ_PERF_EN
    logic [31:0] replay_count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            replay_count_q <= '0;
        end else if (state_q == ST_IDLE && start) begin
            replay_count_q <= '0;
        end else if (refuse && replay_count_q != 32'hFFFF_FFFF) begin
            replay_count_q <= replay_count_q + 32'd1;
        end
    end

    assign replay_count = replay_count_q;
`endif

endmodule

// File: tb/tb_weight_buffer_read_sequencer.sv
// Scoreboard bench: stimulus queues the expected accepted word stream, a negedge monitor
// checks accepts, replay timing and done pulses.
module tb_weight_buffer_read_sequencer;

    localparam int ROWS = 42;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  num_passes = '0;
    logic        out_ready = 1'b0;
    logic [11:0] index;
    logic        out_valid;
    logic [11:0] out_row;
    logic        out_last;
    logic        busy;
    logic        done;
`ifdef WBUF_SEQ_PERF_EN
    logic [31:0] replay_count;
`endif

    weight_buffer_read_sequencer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .num_passes  (num_passes),
        .index       (index),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_row     (out_row),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done)
`ifdef WBUF_SEQ_PERF_EN
        ,
        .replay_count(replay_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] row;
        logic        last;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   rdy_mode = 0;
    bit   arm10 = 1'b0;
    int   n_refuse = 0;
    int   n_done = 0;
    int   zp_req = 0;
    int   zp_ack = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // consumer: 0 always ready, 1 random 50%, 2 refuse row 10 exactly once
    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom_range(0, 1) == 1);
            default: begin
                if (arm10 && out_valid && out_row == 12'd10) begin
                    out_ready = 1'b0;
                    arm10 = 1'b0;
                end else begin
                    out_ready = 1'b1;
                end
            end
        endcase
    end

    bit   done_due = 1'b0;
    bit   nxt_due;
    int   cd = 0;
    int   rr = 0;
    exp_t e;

    always @(negedge clk) begin
        if (!reset_n) begin
            done_due = 1'b0;
            cd = 0;
        end else begin
            nxt_due = 1'b0;
            if (zp_req != zp_ack) begin
                zp_ack = zp_req;
                nxt_due = 1'b1;
            end
            if (done || done_due) chk("done_pulse", done, done_due);
            if (done) n_done++;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    chk("replay_valid", out_valid, 1);
                    chk("replay_row", out_row, rr);
                end else begin
                    chk("replay_gap", out_valid, 0);
                end
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_word_row", out_row, -1);
                end else begin
                    e = sb.pop_front();
                    chk("row", out_row, e.row);
                    chk("last", out_last, e.last);
                    if (e.last) nxt_due = 1'b1;
                end
            end else if (out_valid && !out_ready) begin
                n_refuse++;
                cd = 3;
                rr = out_row;
            end
            done_due = nxt_due;
        end
    end

    task automatic run_seq(input int passes, input int mode, input bit poke, input bit chk_lat);
        int k;
        int snap;
        int d0;
        rdy_mode = mode;
        arm10 = (mode == 2);
        for (int p = 0; p < passes; p++)
            for (int r = 0; r < ROWS; r++)
                sb.push_back('{row: 12'(r), last: (p == passes - 1 && r == ROWS - 1)});
        snap = n_refuse;
        d0 = n_done;
        @(posedge clk); #1;
        start = 1'b1;
        num_passes = 8'(passes);
        if (passes == 0) zp_req++;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy, passes != 0);
        if (chk_lat) begin
            k = 1;
            @(negedge clk);
            while (!out_valid && k < 10) begin
                @(negedge clk);
                k++;
            end
            chk("first_valid_latency", k, 3);
        end
        if (poke) begin
            repeat (15) @(posedge clk);
            #1;
            start = 1'b1;
            num_passes = 8'd7;
            @(posedge clk); #1;
            start = 1'b0;
            chk("busy_after_ignored_start", busy, 1);
        end
        k = 0;
        while (n_done == d0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("sequence_done_seen", n_done != d0, 1);
        chk("scoreboard_empty", sb.size(), 0);
        sb.delete();
        repeat (3) @(negedge clk);
        chk("busy_idle", busy, 0);
        chk("valid_idle", out_valid, 0);
`ifdef WBUF_SEQ_PERF_EN
        chk("replay_count", replay_count, n_refuse - snap);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        #12;
        chk("rst_index", index, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_row", out_row, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        run_seq(1, 0, 0, 1);
        run_seq(3, 0, 0, 0);
        run_seq(1, 2, 0, 0);
        run_seq(2, 1, 0, 0);
        run_seq($urandom_range(1, 3), 1, 0, 0);
        run_seq(0, 0, 0, 0);
        run_seq(1, 0, 1, 0);

        // reset mid-pass at row 20, then a clean restart
        rdy_mode = 0;
        for (int r = 0; r < 2 * ROWS; r++)
            sb.push_back('{row: 12'(r % ROWS), last: (r == 2 * ROWS - 1)});
        @(posedge clk); #1;
        start = 1'b1;
        num_passes = 8'd2;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        @(negedge clk);
        while (!(out_valid && out_row == 12'd20) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("reached_row20", out_row, 20);
        #1;
        reset_n = 1'b0;
        #1;
        chk("midrst_index", index, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_row", out_row, 0);
        chk("midrst_out_last", out_last, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        sb.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        run_seq(1, 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
